// File: rtl/vga_timing_gen_if.sv
// Pixel position / colour / video bus between the timing generator and its neighbours.
interface vga_timing_gen_if;
  logic [9:0] colPos;
  logic [9:0] rowPos;
  logic       pix_en;
  logic [5:0] color_in;
  logic       hsync_n;
  logic       vsync_n;
  logic [5:0] rgb_out;
  logic       video_on;
  logic       frame_start;

  // Timing generator side
  modport master (
    output colPos, rowPos, pix_en, hsync_n, vsync_n, rgb_out, video_on, frame_start,
    input  color_in
  );

  // Pixel generator / DAC side
  modport slave (
    input  colPos, rowPos, pix_en, hsync_n, vsync_n, rgb_out, video_on, frame_start,
    output color_in
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator and video output stage. Sweeps the pixel raster,
// publishes the position, samples the colour reply and drives blanked RGB
// plus active-low syncs delayed to stay aligned with the colour path.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned CLK_DIV   = 1,
  parameter int unsigned COLOR_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  vga_timing_gen_if.master  vga
);

  localparam int unsigned POS_W    = 10;
  localparam int unsigned COLOR_W  = 6;
  localparam int unsigned DIV_W    = 3;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

  logic [DIV_W-1:0]   div_cnt;
  logic               pix_en;
  logic [POS_W-1:0]   col_q;
  logic [POS_W-1:0]   row_q;
  logic               act_raw;
  logic               hs_raw;
  logic               vs_raw;
  logic [COLOR_LAT-1:0] act_q;
  logic [COLOR_LAT-1:0] hs_n_q;
  logic [COLOR_LAT-1:0] vs_n_q;
  logic [COLOR_LAT:0]   act_chain;
  logic [COLOR_LAT:0]   hs_n_chain;
  logic [COLOR_LAT:0]   vs_n_chain;
  logic [COLOR_W-1:0] rgb_q;
  logic               frame_start_q;

  // Pixel strobe: last count of the clock divider
  assign pix_en = (div_cnt == DIV_W'(CLK_DIV - 1));

  // Clock divider, wraps on the pixel strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (pix_en) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Raster counters; they keep running through blanking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else if (pix_en) begin
      if (col_q == POS_W'(H_TOTAL - 1)) begin
        col_q <= '0;
        if (row_q == POS_W'(V_TOTAL - 1)) begin
          row_q <= '0;
        end else begin
          row_q <= row_q + POS_W'(1);
        end
      end else begin
        col_q <= col_q + POS_W'(1);
      end
    end
  end

  // Undelayed region decode of the current position
  assign act_raw = (col_q < POS_W'(H_ACTIVE)) && (row_q < POS_W'(V_ACTIVE));
  assign hs_raw  = (col_q >= POS_W'(HS_START)) && (col_q <= POS_W'(HS_END));
  assign vs_raw  = (row_q >= POS_W'(VS_START)) && (row_q <= POS_W'(VS_END));

  // Bit 0 is the live decode, bit k is the k-pixel delayed copy
  assign act_chain  = {act_q, act_raw};
  assign hs_n_chain = {hs_n_q, ~hs_raw};
  assign vs_n_chain = {vs_n_q, ~vs_raw};

  // Delay line keeps syncs and video_on aligned with the colour reply
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q  <= '0;
      hs_n_q <= '1;
      vs_n_q <= '1;
    end else if (pix_en) begin
      act_q  <= act_chain[COLOR_LAT-1:0];
      hs_n_q <= hs_n_chain[COLOR_LAT-1:0];
      vs_n_q <= vs_n_chain[COLOR_LAT-1:0];
    end
  end

  // Blanked colour register; the stage entering the last delay slot selects visibility
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q <= '0;
    end else if (pix_en) begin
      rgb_q <= act_chain[COLOR_LAT-1] ? vga.color_in : '0;
    end
  end

  // One-clk pulse on the edge that returns the raster to (0,0)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= pix_en && (col_q == POS_W'(H_TOTAL - 1)) &&
                       (row_q == POS_W'(V_TOTAL - 1));
    end
  end

  assign vga.colPos      = col_q;
  assign vga.rowPos      = row_q;
  assign vga.pix_en      = pix_en;
  assign vga.hsync_n     = hs_n_chain[COLOR_LAT];
  assign vga.vsync_n     = vs_n_chain[COLOR_LAT];
  assign vga.video_on    = act_chain[COLOR_LAT];
  assign vga.rgb_out     = rgb_q;
  assign vga.frame_start = frame_start_q;

endmodule
